// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//
// Pipeline control unit for the Y86-64 five-stage PIPE processor. It turns
// the hazard conditions seen in the D/E/M/W registers into stall and bubble
// controls for the pipeline registers. It adds a RUN / FREEZE / HALTED state
// machine with a debug-freeze handshake, and keeps saturating performance
// counters.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   D_icode          icode in the D register
//   d_srcA, d_srcB   decode source registers (4'hF = none)
//   E_icode, E_dstM  icode / memory destination in the E register
//   e_Cnd            branch/cmov condition from execute
//   M_icode          icode in the M register
//   m_stat, W_stat   status out of memory / status in W
//   frz_req          debug freeze request (level)
//   F_stall .. W_stall, set_cc   pipeline register controls (combinational)
//   frz_ack, halted, cpu_stat    registered state / status outputs
//   cyc_cnt, stall_cnt, bubble_cnt, mispred_cnt   saturating counters
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    input  logic             frz_req,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             frz_ack,
    output logic             halted,
    output logic [3:0]       cpu_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_POP   = 4'hB;
    localparam logic [3:0] R_NONE  = 4'hF;

    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FREEZE,
        ST_HALTED
    } state_t;

    state_t state, state_nxt;

    logic lu, rt, mp, m_exc, w_exc;
    logic run;
    logic run_f_stall, run_d_stall, run_d_bubble, run_e_bubble;
    logic run_m_bubble, run_w_stall, run_set_cc;

    function automatic logic is_exc(input logic [3:0] s);
        return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
    endfunction

    // Hazard detection: load/use, return in flight, mispredicted jump.
    assign lu = ((E_icode == I_MRMOV) || (E_icode == I_POP)) &&
                (E_dstM != R_NONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign rt = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mp = (E_icode == I_JXX) && !e_Cnd;

    assign m_exc = is_exc(m_stat);
    assign w_exc = is_exc(W_stat);
    assign run   = (state == ST_RUN);

    // Controls as they apply while running. A load/use stall takes priority
    // over the ret bubble in D so that the load's consumer is not lost.
    assign run_f_stall  = lu | rt;
    assign run_d_stall  = lu;
    assign run_d_bubble = mp | (!lu & rt);
    assign run_e_bubble = mp | lu;
    assign run_m_bubble = m_exc | w_exc;
    assign run_w_stall  = w_exc;
    assign run_set_cc   = (E_icode == I_OPQ) & !m_exc & !w_exc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: an exception in W wins over a freeze request.
    // FREEZE never goes to HALTED because W is held while frozen.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (w_exc) begin
                    state_nxt = ST_HALTED;
                end else if (frz_req) begin
                    state_nxt = ST_FREEZE;
                end
            end
            ST_FREEZE: begin
                if (!frz_req) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_RUN;
        endcase
    end

    // Output logic: outside RUN, F/D/W are held and no bubbles are inserted.
    always_comb begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b1;
        set_cc   = 1'b0;
        if (run) begin
            F_stall  = run_f_stall;
            D_stall  = run_d_stall;
            D_bubble = run_d_bubble;
            E_bubble = run_e_bubble;
            M_bubble = run_m_bubble;
            W_stall  = run_w_stall;
            set_cc   = run_set_cc;
        end
    end

    assign frz_ack = (state == ST_FREEZE);
    assign halted  = (state == ST_HALTED);

    // Processor status latches the faulting W status on entry to HALTED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_stat <= S_AOK;
        end else if (run && w_exc) begin
            cpu_stat <= W_stat;
        end
    end

    // Performance counters count RUN cycles only and stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt     <= '0;
            stall_cnt   <= '0;
            bubble_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (run) begin
            if (cyc_cnt != CNT_MAX) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
            if (run_f_stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((run_d_bubble || run_e_bubble) && (bubble_cnt != CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
            if (mp && (mispred_cnt != CNT_MAX)) begin
                mispred_cnt <= mispred_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the Y86-64 five-stage PIPE processor.
- Sits beside the forwarding/decode logic and drives the stall/bubble controls of the F, D, E, M and W pipeline registers and the condition-code write enable.
- Adds a run/freeze/halt state machine with a debug-freeze handshake.
- Holds saturating performance counters for cycles, stalls, bubbles and branch mispredictions.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- D_icode  input  4  icode in the D register
- d_srcA  input  4  decode source A (4'hF = none)
- d_srcB  input  4  decode source B (4'hF = none)
- E_icode  input  4  icode in the E register
- E_dstM  input  4  memory destination in the E register (4'hF = none)
- e_Cnd  input  1  branch/cmov condition computed in execute
- M_icode  input  4  icode in the M register
- m_stat  input  4  status out of the memory stage
- W_stat  input  4  status in the W register
- frz_req  input  1  debug freeze request (level)
- F_stall  output  1  hold the F register
- D_stall  output  1  hold the D register
- D_bubble  output  1  load a nop into D
- E_bubble  output  1  load a nop into E
- M_bubble  output  1  load a nop into M
- W_stall  output  1  hold the W register
- set_cc  output  1  condition-code write enable
- frz_ack  output  1  registered; high while in FREEZE
- halted  output  1  registered; high while in HALTED
- cpu_stat  output  4  registered processor status
- cyc_cnt  output  CNT_W  RUN cycles
- stall_cnt  output  CNT_W  RUN cycles with F_stall
- bubble_cnt  output  CNT_W  RUN cycles with D_bubble or E_bubble
- mispred_cnt  output  CNT_W  mispredicted jumps

Behaviour:
Encodings:
- JXX=7, RET=9, MRMOV=5, POP=B, OPQ=6.
- AOK=1, HLT=2, ADR=3, INS=4.
- "exc(x)" means x is HLT, ADR or INS.

Hazard terms (combinational):
- lu = (E_icode is MRMOV or POP) and E_dstM != F and (E_dstM == d_srcA or E_dstM == d_srcB).
- rt = RET present in D_icode, E_icode or M_icode.
- mp = (E_icode == JXX) and !e_Cnd.

RUN outputs (combinational from the inputs and the current state):
- F_stall = lu | rt
- D_stall = lu
- D_bubble = mp | (!lu & rt)
- E_bubble = mp | lu
- M_bubble = exc(m_stat) | exc(W_stat)
- W_stall = exc(W_stat)
- set_cc = (E_icode == OPQ) & !exc(m_stat) & !exc(W_stat)

FREEZE and HALTED outputs:
- F_stall = D_stall = W_stall = 1.
- All bubbles = 0; set_cc = 0.
- The E and M registers are held by the datapath's global enable; this block asserts no bubble in these states.

State machine (RUN, FREEZE, HALTED):
- RUN to HALTED when exc(W_stat); cpu_stat <= W_stat on the same edge.
- RUN to FREEZE when frz_req and not exc(W_stat). HALTED wins over FREEZE on a simultaneous event.
- FREEZE to RUN when !frz_req.
- FREEZE to HALTED is not possible because W is stalled.
- HALTED is sticky until rst_n goes low.
- frz_ack = (state == FREEZE). It rises one cycle after frz_req is first seen and falls one cycle after frz_req drops.
- halted = (state == HALTED).
- The cycle in which a transition is decided uses the RUN equations.

Counters:
- Update only in RUN, on the clock edge.
- All four saturate at 2^CNT_W − 1 and never wrap.
- cyc_cnt: +1 every RUN cycle.
- stall_cnt: +1 when F_stall.
- bubble_cnt: +1 when D_bubble | E_bubble.
- mispred_cnt: +1 when mp.

Reset (asynchronous, any time including mid-freeze or halted):
- state = RUN, frz_ack = 0, halted = 0, cpu_stat = AOK, all counters = 0.
- Combinational outputs then follow the RUN equations immediately.

Test Plan:
- Load-use: E_icode=5, E_dstM=3, d_srcB=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt and bubble_cnt +1 each. The same inputs with E_dstM=F give all controls 0.
- Ret: D_icode=9 held for 3 cycles, no lu -> F_stall=1, D_bubble=1 each cycle. Adding lu in that window gives D_stall=1, D_bubble=0.
- Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, mispred_cnt +1. With e_Cnd=1, no bubbles.
- Exception: m_stat=3 with E_icode=6 -> M_bubble=1, set_cc=0. Next W_stat=3 with frz_req=1 in the same cycle -> halted=1 next cycle, cpu_stat=3, frz_ack=0, counters frozen, W_stall=1.
- Freeze: frz_req=1 at cycle 0 -> frz_ack=1 at cycle 1, F/D/W stall=1, cyc_cnt stops. Dropping frz_req at cycle 5 -> frz_ack=0 at cycle 6 and counting resumes.
- Reset/saturation: preload counters to all-ones, stall -> value unchanged. Assert rst_n=0 mid-FREEZE -> frz_ack=0, cpu_stat=1 and counters=0 without a clock edge.
